// File: rtl/gf2m8_arith_unit_if.sv
// Operand/result bundle for the GF(2^8) arithmetic unit.
// The master drives operands and the divider strobe; the slave returns the results.
interface gf2m8_arith_unit_if;
  logic [7:0] mul_x;
  logic [7:0] mul_y;
  logic [7:0] mul_z;
  logic [7:0] inv_b;
  logic [7:0] inv_out;
  logic       div_ena;
  logic [7:0] div_num;
  logic [7:0] div_den;
  logic [7:0] div_q;
  logic       div_valid;
  logic       div_dz;

  modport master (
    output mul_x, mul_y, inv_b, div_ena, div_num, div_den,
    input  mul_z, inv_out, div_q, div_valid, div_dz
  );

  modport slave (
    input  mul_x, mul_y, inv_b, div_ena, div_num, div_den,
    output mul_z, inv_out, div_q, div_valid, div_dz
  );
endinterface

// File: rtl/gf2m8_arith_unit.sv
// GF(2^8) multiplier, inverter and one-cycle divider register for the RS decoder.
// Define GF2M8_ICG_EN to clock the divider register through a latch-based clock gate.
module gf2m8_arith_unit #(
  parameter logic [7:0] POLY = 8'h1D
) (
  input  logic               clk,
  input  logic               rst,
  gf2m8_arith_unit_if.slave  bus
);

  // Shift-and-add product; each shift of the running operand is reduced by {1,POLY}.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ POLY) : {sh[6:0], 1'b0};
    end
    return acc;
  endfunction

  // b^254 = b^2 * b^4 * ... * b^128; b = 0 falls out as 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = b;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] q_next;
  logic       dz_next;
  logic [7:0] div_q_d;
  logic [7:0] div_q_q;
  logic       div_dz_d;
  logic       div_dz_q;
  logic       div_valid_d;
  logic       div_valid_q;

  assign bus.mul_z   = gf_mul(bus.mul_x, bus.mul_y);
  assign bus.inv_out = gf_inv(bus.inv_b);

  always_comb begin
    q_next  = gf_mul(bus.div_num, gf_inv(bus.div_den));
    dz_next = (bus.div_den == 8'h00);
  end

`ifdef GF2M8_ICG_EN
  logic icg_en_q;
  logic gclk;

  // Enable is captured only while clk is low, so gclk cannot glitch during the high phase.
  always_latch begin
    if (rst) begin
      icg_en_q <= 1'b0;
    end else if (!clk) begin
      icg_en_q <= bus.div_ena;
    end
  end

  assign gclk = clk & icg_en_q;

  always_comb begin
    div_q_d  = q_next;
    div_dz_d = dz_next;
  end

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      div_q_q  <= 8'h00;
      div_dz_q <= 1'b0;
    end else begin
      div_q_q  <= div_q_d;
      div_dz_q <= div_dz_d;
    end
  end
`else
  always_comb begin
    div_q_d  = bus.div_ena ? q_next  : div_q_q;
    div_dz_d = bus.div_ena ? dz_next : div_dz_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q_q  <= 8'h00;
      div_dz_q <= 1'b0;
    end else begin
      div_q_q  <= div_q_d;
      div_dz_q <= div_dz_d;
    end
  end
`endif

  always_comb begin
    div_valid_d = bus.div_ena;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_valid_q <= 1'b0;
    end else begin
      div_valid_q <= div_valid_d;
    end
  end

  assign bus.div_q     = div_q_q;
  assign bus.div_dz    = div_dz_q;
  assign bus.div_valid = div_valid_q;

endmodule

// File: tb/tb_gf2m8_arith_unit.sv
// Directed bench for gf2m8_arith_unit: multiplier, inverter sweep, divider latency,
// divide-by-zero, asynchronous reset and back-to-back loads.
module tb_gf2m8_arith_unit;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  logic [7:0] exp_t [0:254];
  int         log_t [0:255];

  gf2m8_arith_unit_if bus();

  gf2m8_arith_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %02h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected alpha^(255-k) for den = alpha^k, k = 1..8
  logic [7:0] b2b_den [0:7];
  logic [7:0] b2b_q   [0:7];

  initial begin
    logic [7:0] v;
    int         li;

    b2b_den = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D};
    b2b_q   = '{8'h8E, 8'h47, 8'hAD, 8'hD8, 8'h6C, 8'h36, 8'h1B, 8'h83};

    // Antilog/log tables from repeated multiplication by alpha
    v = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = v;
      log_t[v] = i;
      v = v[7] ? ({v[6:0], 1'b0} ^ 8'h1D) : {v[6:0], 1'b0};
    end

    n_total = 0;
    n_bad   = 0;
    rst         = 1'b1;
    bus.mul_x   = 8'h00;
    bus.mul_y   = 8'h00;
    bus.inv_b   = 8'h00;
    bus.div_ena = 1'b0;
    bus.div_num = 8'h00;
    bus.div_den = 8'h00;
    #2;
    chk("rst_q", bus.div_q, 8'h00);
    chk("rst_dz", {7'b0, bus.div_dz}, 8'h00);
    chk("rst_valid", {7'b0, bus.div_valid}, 8'h00);

    // Combinational paths, exercised while reset is still asserted
    bus.mul_x = 8'h02; bus.mul_y = 8'h80; #1; chk("mul_02x80", bus.mul_z, 8'h1D);
    bus.mul_x = 8'h04; bus.mul_y = 8'h40; #1; chk("mul_04x40", bus.mul_z, 8'h1D);
    bus.mul_x = 8'h04; bus.mul_y = 8'h8E; #1; chk("mul_04x8E", bus.mul_z, 8'h02);
    bus.mul_x = 8'h8E; bus.mul_y = 8'h04; #1; chk("mul_8Ex04", bus.mul_z, 8'h02);
    bus.mul_x = 8'h37; bus.mul_y = 8'h00; #1; chk("mul_37x00", bus.mul_z, 8'h00);
    bus.mul_x = 8'h01; bus.mul_y = 8'hA5; #1; chk("mul_01xA5", bus.mul_z, 8'hA5);
    bus.inv_b = 8'h01; #1; chk("inv_01", bus.inv_out, 8'h01);
    bus.inv_b = 8'h02; #1; chk("inv_02", bus.inv_out, 8'h8E);
    bus.inv_b = 8'h00; #1; chk("inv_00", bus.inv_out, 8'h00);

    for (int b = 1; b < 256; b++) begin
      bus.inv_b = 8'(b);
      #1;
      li = (255 - log_t[b]) % 255;
      chk($sformatf("inv_sweep_%02h", b), bus.inv_out, exp_t[li]);
      bus.mul_x = 8'(b);
      bus.mul_y = exp_t[li];
      #1;
      chk($sformatf("mul_inv_%02h", b), bus.mul_z, 8'h01);
    end

    @(negedge clk);
    rst = 1'b0;

    // Latency and hold
    bus.div_ena = 1'b1; bus.div_num = 8'h1D; bus.div_den = 8'h02;
    tick();
    chk("div_q_80", bus.div_q, 8'h80);
    chk("div_dz_0", {7'b0, bus.div_dz}, 8'h00);
    chk("div_valid_1", {7'b0, bus.div_valid}, 8'h01);
    bus.div_ena = 1'b0; bus.div_num = 8'h33; bus.div_den = 8'h00;
    tick();
    chk("div_valid_0", {7'b0, bus.div_valid}, 8'h00);
    chk("div_hold_q", bus.div_q, 8'h80);
    chk("div_hold_dz", {7'b0, bus.div_dz}, 8'h00);
    bus.div_num = 8'hC4; bus.div_den = 8'h07;
    tick();
    chk("div_hold_q2", bus.div_q, 8'h80);

    // Divide by zero, then recovery
    bus.div_ena = 1'b1; bus.div_num = 8'h55; bus.div_den = 8'h00;
    tick();
    chk("dz_q", bus.div_q, 8'h00);
    chk("dz_flag", {7'b0, bus.div_dz}, 8'h01);
    bus.div_den = 8'h01;
    tick();
    chk("dz_clr_q", bus.div_q, 8'h55);
    chk("dz_clr_flag", {7'b0, bus.div_dz}, 8'h00);

    // Asynchronous reset between edges
    bus.div_num = 8'h1D; bus.div_den = 8'h02;
    tick();
    chk("pre_rst_q", bus.div_q, 8'h80);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_q", bus.div_q, 8'h00);
    chk("arst_valid", {7'b0, bus.div_valid}, 8'h00);
    chk("arst_dz", {7'b0, bus.div_dz}, 8'h00);
    bus.div_ena = 1'b1; bus.div_num = 8'h1D; bus.div_den = 8'h04;
    #1;
    rst = 1'b0;
    tick();
    chk("post_rst_q", bus.div_q, 8'h40);
    chk("post_rst_valid", {7'b0, bus.div_valid}, 8'h01);

    // Back-to-back loads, den = alpha^k
    bus.div_num = 8'h01;
    for (int k = 0; k < 8; k++) begin
      bus.div_den = b2b_den[k];
      tick();
      chk($sformatf("b2b_q_k%0d", k + 1), bus.div_q, b2b_q[k]);
      chk($sformatf("b2b_valid_k%0d", k + 1), {7'b0, bus.div_valid}, 8'h01);
    end
    bus.div_ena = 1'b0;
    tick();
    chk("b2b_end_valid", {7'b0, bus.div_valid}, 8'h00);
    chk("b2b_end_hold", bus.div_q, 8'h83);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gf2m8_arith_unit.md
Name: gf2m8_arith_unit

Overview:
GF(2^8) arithmetic building block for the RS decoder datapath. It provides three functions:
- a combinational field multiplier;
- a combinational field inverter;
- a clock-gated, one-cycle-latency divider register (num × den⁻¹), the form used by the Chien/Forney error-value path.

Field is GF(2^8) with primitive polynomial x^8+x^4+x^3+x^2+1 (alpha = 0x02, alpha^8 = 0x1D).

Parameters:
POLY  8'h1D  low 8 bits of the primitive polynomial (x^8 term implicit); all field operations reduce by {1'b1,POLY}

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
mul_x  input  8  multiplier operand x
mul_y  input  8  multiplier operand y
mul_z  output  8  combinational x·y in GF(2^8)
inv_b  input  8  inverter operand
inv_out  output  8  combinational inv_b⁻¹; 0 maps to 0
div_ena  input  1  load strobe for the divider register
div_num  input  8  dividend
div_den  input  8  divisor
div_q  output  8  registered div_num·div_den⁻¹
div_valid  output  1  registered copy of div_ena (one-cycle pulse per load)
div_dz  output  1  registered flag: div_den was 0 at the load

Behaviour:
- Multiplier
  - Purely combinational.
  - Polynomial (carry-less) product of x and y, reduced modulo {1,POLY}.
  - Commutative; x·0 = 0; x·1 = x.
- Inverter
  - Purely combinational.
  - Computes b^254 (b⁻¹ for b ≠ 0), e.g. by a square-and-multiply chain built from the multiplier function.
  - b = 0 yields 0; no error flag.
- Divider data path (combinational)
  - q_next = div_num · inv(div_den), using the same multiply and inverse functions.
  - div_den = 0 gives q_next = 0.
- Divider register
  - div_q and div_dz update on a rising clk edge only when div_ena = 1.
  - Otherwise they hold their value indefinitely.
  - The register clock is gated by div_ena (see Optional Feature).
- div_valid
  - Ungated flop, loaded every cycle with div_ena.
  - High exactly in the cycle after each cycle with div_ena = 1.
- Latency
  - mul_z and inv_out: 0 cycles.
  - div_q, div_dz, div_valid: 1 cycle.
  - Back-to-back div_ena cycles give one result per cycle; div_valid stays high throughout.
- Reset (rst = 1, asynchronous)
  - div_q = 8'h00, div_dz = 0, div_valid = 0 immediately, independent of clk.
  - Combinational outputs are unaffected by reset.
- Reset release
  - Takes effect at the next clk edge.
  - If div_ena = 1 at that first edge, the load occurs normally.
- Reset mid-operation
  - Any pending or held result is discarded.
  - No output glitches to a non-reset value while rst = 1.
- Operand changes while div_ena = 0 must not alter div_q or div_dz.

Optional Feature:
Macro GF2M8_ICG_EN.
- Defined:
  - Divider register is clocked by an integrated clock gate.
  - Enable is latched while clk is low: a transparent-low latch, cleared asynchronously by rst.
  - Gated clock = clk AND latched enable; the flops load unconditionally on the gated clock.
  - Enable changes while clk is high must not glitch the gated clock.
- Undefined:
  - Plain clk with a synchronous load-enable mux.
- Port-level cycle behaviour is identical in both builds.

Test Plan:
1. Multiplier: 0x02×0x80 → 0x1D; 0x04×0x40 → 0x1D; 0x04×0x8E → 0x02; 0x37×0x00 → 0x00; 0x01×0xA5 → 0xA5.
2. Inverter: inv_b=0x01 → 0x01; 0x02 → 0x8E; 0x00 → 0x00. Exhaustive sweep of all 255 nonzero b checks b·inv(b) = 0x01.
3. Divider latency: div_ena=1, num=0x1D, den=0x02 at edge N → div_q=0x80, div_dz=0, div_valid=1 after edge N. div_ena=0 at edge N+1 → div_valid=0, div_q holds 0x80 while operands change.
4. Divide-by-zero: div_ena=1, num=0x55, den=0x00 → div_q=0x00, div_dz=1; next load with den=0x01, num=0x55 → div_q=0x55, div_dz=0.
5. Async reset: after a load giving div_q=0x80, assert rst between clock edges → div_q=0x00, div_valid=0, div_dz=0 immediately. Release rst with div_ena=1, num=0x1D, den=0x04 → next edge div_q=0x40.
6. Back-to-back loads over 8 cycles with den = alpha^k, num = 0x01, k = 1..8 → each cycle div_q = alpha^(255−k), div_valid held 1. Run in both GF2M8_ICG_EN builds with identical results.
